gpio_in_cond: RTL and testbench
===============================

# gpio_in_cond

Pad-side input conditioning stage that directly feeds the 16-bit `WGPIODIN` read port of the AHB-Lite GPIO register block. It synchronises raw pad inputs into the `HCLK` domain and optionally debounces each pin with a shared prescaled tick. It also detects rising and falling edges on the conditioned value and holds them as sticky, maskable interrupt-pending bits with a single OR-reduced interrupt output.

## Interface
- `WIDTH`, 16, number of GPIO pins.
- `CNT_W`, 8, width of each per-pin debounce counter and of `DB_THRESH`.
- `HCLK`  in  1  system clock; all state updates on its rising edge.
- `HRESET`  in  1  asynchronous, active-high reset.
- `PAD_IN`  in  WIDTH  raw pad inputs, asynchronous to `HCLK`.
- `DB_EN`  in  WIDTH  per-pin debounce enable; 0 selects bypass.
- `DB_PRESCALE`  in  16  tick divider; one tick every `DB_PRESCALE+1` cycles.
- `DB_THRESH`  in  CNT_W  debounce threshold, counted in ticks.
- `RISE_EN`  in  WIDTH  rising-edge interrupt enable per pin.
- `FALL_EN`  in  WIDTH  falling-edge interrupt enable per pin.
- `IRQ_CLR`  in  WIDTH  per-pin clear of pending bits; level, sampled each cycle.
- `WGPIODIN`  out  WIDTH  conditioned pin value; drives the GPIO block's `WGPIODIN`.
- `IRQ_PEND`  out  WIDTH  sticky pending edge flags.
- `IRQ`  out  1  OR of `IRQ_PEND`, registered.

## Operation
- **Synchroniser.** Two flops per pin: `s1 <= PAD_IN`, `s2 <= s1`. No other logic reads `PAD_IN`.
- **Prescaler.** A 16-bit counter `pc` drives the debounce tick.
  - `tick = (pc == DB_PRESCALE)`.
  - On `tick`, `pc <= 0`; otherwise `pc <= pc+1`.
  - If `DB_PRESCALE` is lowered below the current `pc`, `pc` counts up and wraps at 2^16, then behaves normally. This is accepted behaviour.
- **Stable register.** A per-pin `stable` register drives `WGPIODIN`.
- **Bypass pin** (`DB_EN[i]=0`): `stable[i] <= s2[i]` every cycle, and `cnt[i] <= 0`.
- **Debounced pin** (`DB_EN[i]=1`): evaluate in this order each cycle.
  - If `s2[i]==stable[i]`: `cnt[i] <= 0`.
  - Else if `tick` and `cnt[i] >= DB_THRESH`: `stable[i] <= s2[i]`, `cnt[i] <= 0`.
  - Else if `tick`: `cnt[i] <= cnt[i]+1`.
  - Else: hold.
  - The `>=` comparison covers a threshold lowered mid-count.
  - `cnt` never wraps, because it resets at the threshold.
- **Edge detect.** Computed on `stable` versus its next value in the same cycle.
  - `rise[i] = ~stable[i] & stable_nxt[i]`; `fall[i] = stable[i] & ~stable_nxt[i]`.
  - `set[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])`.
- **Pending bits.** `IRQ_PEND[i] <= set[i] | (IRQ_PEND[i] & ~IRQ_CLR[i])`. When set and clear occur in the same cycle, set wins.
- **Interrupt output.** `IRQ <= |(next IRQ_PEND)`, so `IRQ` asserts in the same cycle as `IRQ_PEND`.
- **Enable changes.**
  - Disabling `RISE_EN`/`FALL_EN` does not clear already-pending bits.
  - Toggling `DB_EN[i]` 1→0 mid-count: `stable` follows `s2` on the next edge and `cnt` clears. An edge produced by that update sets pending if enabled.

## Timing
- **Reset.** While `HRESET`=1 (asynchronous assert), `s1`, `s2`, `stable`, all `cnt`, `pc`, `IRQ_PEND` and `IRQ` are 0, so `WGPIODIN=0`.
- **First edge after reset release.** A pin held at 1 is synchronised normally. It produces a rise event if `RISE_EN` is set, which is intended.
- **Reset mid-debounce.** Discards the count. No partial state survives.
- **Bypass latency.** A `PAD_IN` change is visible on `WGPIODIN` and `IRQ_PEND`/`IRQ` after 3 rising edges (`s1`, `s2`, `stable`).
- **Debounce latency** (`DB_PRESCALE=0`, `DB_THRESH=N`): mismatch must be present at `s2` for N+1 consecutive edges.
  - `stable` updates on the (N+1)th edge.
  - Total pad-to-`WGPIODIN` latency is N+3 edges.
  - Any return to equality before then resets `cnt`.
- **Debounce latency** (`DB_PRESCALE=P`): `stable` updates on the (N+1)th tick with mismatch continuously present. Resolution is P+1 cycles.
- **Pin independence.** All pins are independent. Several pins may update and set pending in the same cycle.

## Test plan
- **Bypass.** Reset, `DB_EN=0`, `RISE_EN=16'h0001`, then `PAD_IN=16'h0001`.
  - `WGPIODIN=16'h0001` exactly 3 edges later.
  - `IRQ_PEND=16'h0001` and `IRQ=1` on the same edge.
- **Clear and set/clear collision.**
  - `IRQ_CLR=16'h0001` for one cycle → `IRQ_PEND=0` and `IRQ=0` next edge.
  - Assert `IRQ_CLR` on the same edge a new rise arrives → `IRQ_PEND` stays 1.
- **Debounce glitch.** `DB_EN=16'hFFFF`, `DB_PRESCALE=0`, `DB_THRESH=4`.
  - 4-cycle high pulse on pin 3 → `WGPIODIN` stays 0, no pending.
  - 5+ cycle high on pin 3 → `WGPIODIN[3]=1` at edge 7 after the pad change.
- **Prescaled debounce.** `DB_PRESCALE=9`, `DB_THRESH=2`, pin 7 held high → `WGPIODIN[7]` rises on the 3rd tick, 21–30 cycles after `s2` changes depending on prescaler phase. Checked against a reference model.
- **Falling-edge masking.** `FALL_EN=16'h8000`, `RISE_EN=0`.
  - Toggle pin 15 1→0 → `IRQ_PEND[15]=1`.
  - Toggle pin 14 → no pending.
  - Clear `FALL_EN` → `IRQ_PEND[15]` stays 1.
- **Reset mid-operation.** Assert `HRESET` mid-count with pending bits set.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the pad still high on pin 0 with `RISE_EN[0]=1` gives `IRQ_PEND[0]=1` once `stable` updates.

Source files
------------

// File: rtl/gpio_in_cond_if.sv
// rtl/gpio_in_cond_if.sv - pad-side and register-side signal bundle for gpio_in_cond
interface gpio_in_cond_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] PAD_IN;
    logic [WIDTH-1:0] DB_EN;
    logic [15:0]      DB_PRESCALE;
    logic [CNT_W-1:0] DB_THRESH;
    logic [WIDTH-1:0] RISE_EN;
    logic [WIDTH-1:0] FALL_EN;
    logic [WIDTH-1:0] IRQ_CLR;
    logic [WIDTH-1:0] WGPIODIN;
    logic [WIDTH-1:0] IRQ_PEND;
    logic             IRQ;

    modport master (
        output PAD_IN, DB_EN, DB_PRESCALE, DB_THRESH, RISE_EN, FALL_EN, IRQ_CLR,
        input  WGPIODIN, IRQ_PEND, IRQ
    );

    modport slave (
        input  PAD_IN, DB_EN, DB_PRESCALE, DB_THRESH, RISE_EN, FALL_EN, IRQ_CLR,
        output WGPIODIN, IRQ_PEND, IRQ
    );
endinterface

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO input synchroniser, per-pin debouncer and sticky edge interrupts
module gpio_in_cond #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic          HCLK,
    input  logic          HRESET,
    gpio_in_cond_if.slave gpio
);
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [15:0]      pc_q, pc_d;
    logic             irq_q, irq_d;
    logic             tick;
    logic [WIDTH-1:0] rise, fall, set;

    // Shared prescaler; a lowered DB_PRESCALE below pc simply wraps through 2^16.
    always_comb begin
        tick = (pc_q == gpio.DB_PRESCALE);
        pc_d = tick ? 16'd0 : pc_q + 16'd1;
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!gpio.DB_EN[i]) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] >= gpio.DB_THRESH)) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edges are taken against the value about to be registered so pending tracks WGPIODIN exactly.
    always_comb begin
        rise   = ~stable_q & stable_d;
        fall   = stable_q & ~stable_d;
        set    = (rise & gpio.RISE_EN) | (fall & gpio.FALL_EN);
        pend_d = set | (pend_q & ~gpio.IRQ_CLR);
        irq_d  = |pend_d;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
            pc_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= gpio.PAD_IN;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            pc_q     <= pc_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio.WGPIODIN = stable_q;
    assign gpio.IRQ_PEND = pend_q;
    assign gpio.IRQ      = irq_q;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb/tb_gpio_in_cond.sv - randomized and directed bench for gpio_in_cond against a behavioural model
module tb_gpio_in_cond;
    localparam int W  = 16;
    localparam int CW = 8;

    logic HCLK = 1'b0;
    logic HRESET;

    gpio_in_cond_if #(.WIDTH(W), .CNT_W(CW)) gif ();

    gpio_in_cond #(.WIDTH(W), .CNT_W(CW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .gpio   (gif)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: pad history, debounced value, ticks seen during the current mismatch run.
    logic [W-1:0] m_s1, m_s2, m_stable, m_pend;
    logic         m_irq;
    int           m_run [W];
    int           m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_irq = 1'b0; m_phase = 0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic         tk;
        logic [W-1:0] nxt, st;
        tk  = (m_phase == int'(gif.DB_PRESCALE));
        nxt = m_stable;
        for (int i = 0; i < W; i++) begin
            if (!gif.DB_EN[i]) begin
                nxt[i] = m_s2[i];
                m_run[i] = 0;
            end else if (m_s2[i] == m_stable[i]) begin
                m_run[i] = 0;
            end else if (tk) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > int'(gif.DB_THRESH)) begin
                    nxt[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        st       = (~m_stable & nxt & gif.RISE_EN) | (m_stable & ~nxt & gif.FALL_EN);
        m_pend   = st | (m_pend & ~gif.IRQ_CLR);
        m_irq    = (m_pend != 0);
        m_stable = nxt;
        m_s2     = m_s1;
        m_s1     = gif.PAD_IN;
        m_phase  = tk ? 0 : (m_phase + 1) % 65536;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge HCLK);
        #1;
        check("wgpiodin", 32'(gif.WGPIODIN), 32'(m_stable));
        check("irq_pend", 32'(gif.IRQ_PEND), 32'(m_pend));
        check("irq", 32'(gif.IRQ), 32'(m_irq));
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        gif.PAD_IN = '0; gif.DB_EN = '0; gif.DB_PRESCALE = '0; gif.DB_THRESH = '0;
        gif.RISE_EN = '0; gif.FALL_EN = '0; gif.IRQ_CLR = '0;
        HRESET = 1'b1;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_wgpiodin", 32'(gif.WGPIODIN), 32'h0);
        check("rst_pend", 32'(gif.IRQ_PEND), 32'h0);
        check("rst_irq", 32'(gif.IRQ), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Bypass latency: three edges pad to output.
        gif.RISE_EN = 16'h0001;
        gif.PAD_IN  = 16'h0001;
        cycles(2);
        check("byp_early", 32'(gif.WGPIODIN), 32'h0);
        cycle();
        check("byp_din", 32'(gif.WGPIODIN), 32'h0001);
        check("byp_pend", 32'(gif.IRQ_PEND), 32'h0001);
        check("byp_irq", 32'(gif.IRQ), 32'h1);

        // Clear, then clear colliding with a fresh rise.
        gif.IRQ_CLR = 16'h0001;
        cycle();
        gif.IRQ_CLR = '0;
        check("clr_pend", 32'(gif.IRQ_PEND), 32'h0);
        check("clr_irq", 32'(gif.IRQ), 32'h0);
        gif.PAD_IN = '0;
        cycles(4);
        gif.PAD_IN = 16'h0001;
        cycles(2);
        gif.IRQ_CLR = 16'h0001;
        cycle();
        gif.IRQ_CLR = '0;
        check("coll_pend", 32'(gif.IRQ_PEND), 32'h0001);

        // Debounce glitch rejection and acceptance on pin 3.
        gif.DB_EN = 16'hFFFF; gif.DB_PRESCALE = 16'd0; gif.DB_THRESH = 8'd4;
        gif.PAD_IN[3] = 1'b1;
        cycles(4);
        gif.PAD_IN[3] = 1'b0;
        cycles(10);
        check("glitch_din3", 32'(gif.WGPIODIN[3]), 32'h0);
        check("glitch_pend3", 32'(gif.IRQ_PEND[3]), 32'h0);
        gif.PAD_IN[3] = 1'b1;
        cycles(6);
        check("db_edge6", 32'(gif.WGPIODIN[3]), 32'h0);
        cycle();
        check("db_edge7", 32'(gif.WGPIODIN[3]), 32'h1);

        // Prescaled debounce on pin 7: rise lands 21..30 cycles after s2 changes.
        gif.DB_PRESCALE = 16'd9; gif.DB_THRESH = 8'd2;
        gif.PAD_IN[7] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (lat < 0 && gif.WGPIODIN[7]) lat = k - 2;
        end
        check("pre_lat_range", 32'((lat >= 21) && (lat <= 30)), 32'h1);

        // Falling-edge masking in bypass.
        gif.DB_EN = '0; gif.DB_PRESCALE = '0;
        gif.RISE_EN = '0; gif.FALL_EN = 16'h8000;
        gif.PAD_IN[15] = 1'b1; gif.PAD_IN[14] = 1'b1;
        cycles(4);
        gif.IRQ_CLR = 16'hFFFF;
        cycle();
        gif.IRQ_CLR = '0;
        gif.PAD_IN[15] = 1'b0;
        cycles(3);
        check("fall15_pend", 32'(gif.IRQ_PEND[15]), 32'h1);
        gif.PAD_IN[14] = 1'b0;
        cycles(3);
        check("fall14_masked", 32'(gif.IRQ_PEND[14]), 32'h0);
        gif.FALL_EN = '0;
        cycles(3);
        check("fall15_sticky", 32'(gif.IRQ_PEND[15]), 32'h1);

        // Randomized stretch: sparse pad toggles against random enables and thresholds.
        r = $urandom;
        gif.DB_PRESCALE = 16'($urandom_range(0, 3));
        for (int k = 0; k < 800; k++) begin
            r = $urandom & $urandom & $urandom;
            gif.PAD_IN = gif.PAD_IN ^ r[W-1:0];
            if ($urandom_range(0, 31) == 0) gif.DB_EN = W'($urandom);
            if ($urandom_range(0, 63) == 0) gif.DB_THRESH = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) begin
                gif.RISE_EN = W'($urandom);
                gif.FALL_EN = W'($urandom);
            end
            r = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            gif.IRQ_CLR = r[W-1:0];
            cycle();
        end

        // Asynchronous reset in the middle of a debounce count with bits pending.
        gif.IRQ_CLR = '0; gif.DB_PRESCALE = '0; gif.DB_EN = '0;
        gif.RISE_EN = 16'hFFFF; gif.FALL_EN = '0;
        gif.PAD_IN = '0;
        cycles(4);
        gif.PAD_IN = 16'h0001;
        cycles(4);
        gif.DB_EN = 16'h0002; gif.DB_THRESH = 8'd20;
        gif.PAD_IN = 16'h0003;
        cycles(6);
        check("pre_rst_pend", 32'(gif.IRQ_PEND[0]), 32'h1);
        #2;
        HRESET = 1'b1;
        model_reset();
        #1;
        check("arst_din", 32'(gif.WGPIODIN), 32'h0);
        check("arst_pend", 32'(gif.IRQ_PEND), 32'h0);
        check("arst_irq", 32'(gif.IRQ), 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        cycles(3);
        check("post_rst_pend0", 32'(gif.IRQ_PEND[0]), 32'h1);
        check("post_rst_din1", 32'(gif.WGPIODIN[1]), 32'h0);
        cycles(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
